// File: rtl/write_back_stage_if.sv
// MEM/WB boundary bundle: MEM-stage instruction and data-memory response in,
// register-file write port and upstream stall out.
interface write_back_stage_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  mem_valid;
  logic [1:0]            mem_wb_control;
  logic [REG_ADDR_W-1:0] mem_rw;
  logic [DATA_W-1:0]     mem_alu_result;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_rdata_valid;
  logic                  flush;
  logic                  stall_req;
  logic                  reg_write;
  logic [REG_ADDR_W-1:0] rw;
  logic [DATA_W-1:0]     busw;

  modport master (
    output mem_valid, mem_wb_control, mem_rw, mem_alu_result,
           mem_rdata, mem_rdata_valid, flush,
    input  stall_req, reg_write, rw, busw
  );

  modport slave (
    input  mem_valid, mem_wb_control, mem_rw, mem_alu_result,
           mem_rdata, mem_rdata_valid, flush,
    output stall_req, reg_write, rw, busw
  );
endinterface

// File: rtl/write_back_stage.sv
// MEM/WB register and write-back sequencer: ALU results write after one cycle,
// loads wait for the memory response (with timeout). Define WB_FWD_EN for forwarding taps.
module write_back_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_TMO   = 16,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  write_back_stage_if.slave     wb,
  output logic                  load_err,
  output logic [CNT_W-1:0]      commit_cnt
`ifdef WB_FWD_EN
  ,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_rw,
  output logic [DATA_W-1:0]     fwd_data,
  output logic                  pend_load,
  output logic [REG_ADDR_W-1:0] pend_rw
`endif
);

  localparam int TMO_W = $clog2(LOAD_TMO + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOAD_TMO - 1);

  typedef enum logic {IDLE = 1'b0, WAIT_MEM = 1'b1} state_t;

  state_t                state_p1, state_d;
  logic [TMO_W-1:0]      tmo_p1;
  logic                  we_lat_p1;
  logic [REG_ADDR_W-1:0] rw_lat_p1;
  logic                  reg_write_p1;
  logic [REG_ADDR_W-1:0] rw_p1;
  logic [DATA_W-1:0]     busw_p1;

  logic cap_alu, cap_load, load_done, tmo_hit;

  always_comb begin
    state_d   = state_p1;
    cap_alu   = 1'b0;
    cap_load  = 1'b0;
    load_done = 1'b0;
    tmo_hit   = 1'b0;
    case (state_p1)
      IDLE: begin
        if (wb.mem_valid && !wb.flush) begin
          if (wb.mem_wb_control[0]) begin
            cap_load = 1'b1;
            state_d  = WAIT_MEM;
          end else begin
            cap_alu = 1'b1;
          end
        end
      end
      WAIT_MEM: begin
        // flush beats a same-cycle response; the response beats the timeout
        if (wb.flush) begin
          state_d = IDLE;
        end else if (wb.mem_rdata_valid) begin
          load_done = 1'b1;
          state_d   = IDLE;
        end else if (tmo_p1 == TMO_LAST) begin
          tmo_hit = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // write-back register stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p1     <= IDLE;
      tmo_p1       <= '0;
      we_lat_p1    <= 1'b0;
      rw_lat_p1    <= '0;
      reg_write_p1 <= 1'b0;
      rw_p1        <= '0;
      busw_p1      <= '0;
      load_err     <= 1'b0;
      commit_cnt   <= '0;
    end else begin
      state_p1     <= state_d;
      reg_write_p1 <= 1'b0;
      if (cap_alu) begin
        reg_write_p1 <= wb.mem_wb_control[1] && (wb.mem_rw != '0);
        rw_p1        <= wb.mem_rw;
        busw_p1      <= wb.mem_alu_result;
        commit_cnt   <= commit_cnt + CNT_W'(1);
      end
      if (cap_load) begin
        we_lat_p1 <= wb.mem_wb_control[1];
        rw_lat_p1 <= wb.mem_rw;
        tmo_p1    <= '0;
      end else if (state_p1 == WAIT_MEM && !load_done && !tmo_hit && !wb.flush) begin
        tmo_p1 <= tmo_p1 + TMO_W'(1);
      end
      if (load_done) begin
        reg_write_p1 <= we_lat_p1 && (rw_lat_p1 != '0);
        rw_p1        <= rw_lat_p1;
        busw_p1      <= wb.mem_rdata;
        commit_cnt   <= commit_cnt + CNT_W'(1);
      end
      if (tmo_hit) begin
        load_err <= 1'b1;
      end
    end
  end

  assign wb.stall_req = (state_p1 == WAIT_MEM);
  assign wb.reg_write = reg_write_p1;
  assign wb.rw        = rw_p1;
  assign wb.busw      = busw_p1;

`ifdef WB_FWD_EN
  assign fwd_valid = reg_write_p1;
  assign fwd_rw    = rw_p1;
  assign fwd_data  = busw_p1;
  assign pend_load = (state_p1 == WAIT_MEM) && we_lat_p1;
  assign pend_rw   = rw_lat_p1;
`endif

endmodule

// File: tb/tb_write_back_stage.sv
// Randomized bench for write_back_stage against a transaction-level reference model.
module tb_write_back_stage;
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int LOAD_TMO   = 16;
  localparam int CNT_W      = 8;

  logic             clk;
  logic             rst_n;
  logic             load_err;
  logic [CNT_W-1:0] commit_cnt;

  write_back_stage_if #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) wbif ();

  write_back_stage #(
    .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .LOAD_TMO(LOAD_TMO), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wb(wbif.slave),
    .load_err(load_err), .commit_cnt(commit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: at most one outstanding load, tracked with its age in cycles.
  bit                    pend;
  int                    pend_age;
  bit                    pend_we;
  logic [REG_ADDR_W-1:0] pend_rw;
  bit                    e_we;
  logic [REG_ADDR_W-1:0] e_rw;
  logic [DATA_W-1:0]     e_busw;
  bit                    e_err;
  int                    commits;

  task automatic model_edge();
    if (!rst_n) begin
      pend = 0; pend_age = 0; pend_we = 0; pend_rw = '0;
      e_we = 0; e_rw = '0; e_busw = '0; e_err = 0; commits = 0;
      return;
    end
    e_we = 0;
    if (pend) begin
      if (wbif.flush) begin
        pend = 0;
      end else if (wbif.mem_rdata_valid) begin
        e_we    = pend_we && (pend_rw != 0);
        e_rw    = pend_rw;
        e_busw  = wbif.mem_rdata;
        commits = commits + 1;
        pend    = 0;
      end else begin
        pend_age = pend_age + 1;
        if (pend_age >= LOAD_TMO) begin
          pend  = 0;
          e_err = 1;
        end
      end
    end else if (wbif.mem_valid && !wbif.flush) begin
      if (wbif.mem_wb_control[0]) begin
        pend = 1; pend_age = 0;
        pend_we = wbif.mem_wb_control[1];
        pend_rw = wbif.mem_rw;
      end else begin
        e_we    = wbif.mem_wb_control[1] && (wbif.mem_rw != 0);
        e_rw    = wbif.mem_rw;
        e_busw  = wbif.mem_alu_result;
        commits = commits + 1;
      end
    end
  endtask

  task automatic compare_all();
    check_eq("reg_write",  64'(wbif.reg_write), 64'(e_we));
    check_eq("rw",         64'(wbif.rw),        64'(e_rw));
    check_eq("busw",       64'(wbif.busw),      64'(e_busw));
    check_eq("stall_req",  64'(wbif.stall_req), 64'(pend));
    check_eq("load_err",   64'(load_err),       64'(e_err));
    check_eq("commit_cnt", 64'(commit_cnt),     64'(commits % (1 << CNT_W)));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    wbif.mem_valid = 0; wbif.mem_wb_control = 2'b00; wbif.mem_rw = '0;
    wbif.mem_alu_result = '0; wbif.mem_rdata = '0; wbif.mem_rdata_valid = 0;
    wbif.flush = 0;
  endtask

  task automatic issue(input logic [1:0] ctrl, input logic [4:0] r, input logic [31:0] alu);
    wbif.mem_valid = 1; wbif.mem_wb_control = ctrl; wbif.mem_rw = r;
    wbif.mem_alu_result = alu;
    step();
    idle_inputs();
  endtask

  task automatic do_reset();
    rst_n = 0; idle_inputs();
    step(); step();
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    do_reset();
    check_eq("rst_commit", 64'(commit_cnt), 64'd0);
    check_eq("rst_stall",  64'(wbif.stall_req), 64'd0);

    // ALU write
    issue(2'b10, 5'd5, 32'h0000_00AA);
    check_eq("alu_we",   64'(wbif.reg_write), 64'd1);
    check_eq("alu_rw",   64'(wbif.rw),        64'd5);
    check_eq("alu_busw", 64'(wbif.busw),      64'hAA);
    check_eq("alu_cnt",  64'(commit_cnt),     64'd1);

    // Load answered on the third wait cycle
    issue(2'b11, 5'd7, 32'h1234);
    check_eq("ld_stall0", 64'(wbif.stall_req), 64'd1);
    step();
    check_eq("ld_stall1", 64'(wbif.stall_req), 64'd1);
    step();
    check_eq("ld_stall2", 64'(wbif.stall_req), 64'd1);
    wbif.mem_rdata_valid = 1; wbif.mem_rdata = 32'hDEAD_BEEF;
    step();
    idle_inputs();
    check_eq("ld_we",    64'(wbif.reg_write), 64'd1);
    check_eq("ld_busw",  64'(wbif.busw),      64'hDEAD_BEEF);
    check_eq("ld_rw",    64'(wbif.rw),        64'd7);
    check_eq("ld_stall", 64'(wbif.stall_req), 64'd0);

    // r0 and non-writing instructions still commit
    issue(2'b10, 5'd0, 32'h55);
    check_eq("r0_we", 64'(wbif.reg_write), 64'd0);
    issue(2'b00, 5'd3, 32'h66);
    check_eq("nw_we",  64'(wbif.reg_write), 64'd0);
    check_eq("nw_cnt", 64'(commit_cnt),     64'd4);

    // Timeout
    issue(2'b11, 5'd9, 32'h0);
    for (int i = 1; i < LOAD_TMO; i++) step();
    check_eq("tmo_stall_last", 64'(wbif.stall_req), 64'd1);
    step();
    check_eq("tmo_stall", 64'(wbif.stall_req), 64'd0);
    check_eq("tmo_err",   64'(load_err),       64'd1);
    check_eq("tmo_cnt",   64'(commit_cnt),     64'd4);

    // Flush beats a same-cycle response
    do_reset();
    issue(2'b11, 5'd4, 32'h0);
    step();
    wbif.flush = 1; wbif.mem_rdata_valid = 1; wbif.mem_rdata = 32'hCAFE;
    step();
    idle_inputs();
    check_eq("fl_we",    64'(wbif.reg_write), 64'd0);
    check_eq("fl_stall", 64'(wbif.stall_req), 64'd0);
    check_eq("fl_err",   64'(load_err),       64'd0);

    // Reset in the middle of a load; a late response is ignored
    issue(2'b11, 5'd6, 32'h0);
    rst_n = 0;
    step();
    rst_n = 1;
    check_eq("rml_stall", 64'(wbif.stall_req), 64'd0);
    check_eq("rml_busw",  64'(wbif.busw),      64'd0);
    wbif.mem_rdata_valid = 1; wbif.mem_rdata = 32'hBAD0;
    step();
    idle_inputs();
    check_eq("rml_late_we", 64'(wbif.reg_write), 64'd0);

    // Randomized traffic, long enough to wrap the commit counter
    for (int c = 0; c < 4000; c++) begin
      rst_n                = ($urandom_range(0, 499) != 0);
      wbif.mem_valid       = ($urandom_range(0, 3) != 0);
      wbif.mem_wb_control  = 2'($urandom_range(0, 3));
      wbif.mem_rw          = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      wbif.mem_alu_result  = $urandom;
      wbif.mem_rdata       = $urandom;
      wbif.mem_rdata_valid = ($urandom_range(0, 4) == 0);
      wbif.flush           = ($urandom_range(0, 23) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
